// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset vector, bubble
// instruction, memory region codes and the fetch-source encoding.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h4000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [3:0] REGION_BIOS = 4'h4;
  localparam logic [3:0] REGION_IMEM = 4'h1;

  typedef enum logic [1:0] {
    SRC_BIOS = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_NONE = 2'd2
  } src_e;

  // Map the top address nibble onto the memory that backs it.
  function automatic src_e region_decode(input logic [3:0] region);
    src_e src;
    case (region)
      REGION_BIOS: src = SRC_BIOS;
      REGION_IMEM: src = SRC_IMEM;
      default:     src = SRC_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// Program counter generator: owns pc_q and the registered fetch source, and
// drives both memory addresses from the next PC so read data lines up with
// pc_q one cycle later.
module pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output src_e        src_o,
  output logic [11:0] bios_addr_o,
  output logic [13:0] imem_addr_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  src_e        src_q;
  src_e        src_d;

  // Next fetch address: reset vector, hold, word-aligned redirect, or sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (hold_i) begin
      pc_d = pc_q;
    end else if (redirect_i) begin
      pc_d = target_i & 32'hFFFF_FFFC;
    end else begin
      pc_d = pc_q + 32'd4;
    end
    src_d = region_decode(pc_d[31:28]);
  end

  // PC and fetch-source registers advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      src_q <= SRC_BIOS;
    end else begin
      pc_q  <= pc_d;
      src_q <= src_d;
    end
  end

  assign pc_o        = pc_q;
  assign src_o       = src_q;
  assign bios_addr_o = pc_d[13:2];
  assign imem_addr_o = pc_d[15:2];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, memory source select, bubble
// insertion for the first post-reset cycle and unmapped fetches, plus the
// cycle and retired-instruction counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        should_br,
  input  logic        jump,
  input  logic [31:0] ALU_result,
  output logic [11:0] bios_addrb,
  input  logic [31:0] bios_doutb,
  output logic [13:0] imem_addrb,
  input  logic [31:0] imem_doutb,
  output logic [31:0] PC,
  output logic [31:0] instruction_EXE,
  output logic        valid_EXE,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  src_e        src_s;
  logic        first_q;
  logic        hold_s;
  logic        redirect_s;
  logic        valid_s;
  logic [31:0] fetched_s;
  logic [31:0] cycle_q;
  logic [31:0] cycle_d;
  logic [31:0] instret_q;
  logic [31:0] instret_d;

  // The memory output is not yet trustworthy in the first cycle after reset,
  // so the PC is held there and the cycle is presented as a bubble.
  assign hold_s     = stall | first_q;
  assign redirect_s = should_br | jump;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold_s),
    .redirect_i  (redirect_s),
    .target_i    (ALU_result),
    .pc_o        (PC),
    .src_o       (src_s),
    .bios_addr_o (bios_addrb),
    .imem_addr_o (imem_addrb)
  );

  assign valid_s = ~first_q & (src_s != SRC_NONE);

  // Select the memory backing the current PC and substitute a NOP for bubbles.
  always_comb begin
    fetched_s       = NOP_INSTR;
    instruction_EXE = NOP_INSTR;
    case (src_s)
      SRC_BIOS: fetched_s = bios_doutb;
      SRC_IMEM: fetched_s = imem_doutb;
      default:  fetched_s = NOP_INSTR;
    endcase
    if (valid_s) begin
      instruction_EXE = fetched_s;
    end else begin
      instruction_EXE = NOP_INSTR;
    end
  end

  // Counter next-state: free-running cycle count, retire on valid unstalled.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q;
    if (valid_s && !stall) begin
      instret_d = instret_q + 32'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // First-cycle flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q   <= 1'b1;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      first_q   <= 1'b0;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign valid_EXE   = valid_s;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver applies directed and random
// control inputs and pushes the expected per-cycle outputs computed by a
// reference model; a monitor pops and compares on the falling edge.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        should_br;
  logic        jump;
  logic [31:0] ALU_result;
  logic [11:0] bios_addrb;
  logic [31:0] bios_doutb;
  logic [13:0] imem_addrb;
  logic [31:0] imem_doutb;
  logic [31:0] PC;
  logic [31:0] instruction_EXE;
  logic        valid_EXE;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  logic [31:0] bios_mem [0:4095];
  logic [31:0] imem_mem [0:16383];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cyc;
    logic [31:0] inst;
    logic [11:0] ba;
    logic [13:0] ia;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_known = 0;
  bit          m_first = 0;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_cyc   = 32'd0;
  logic [31:0] m_inst  = 32'd0;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .should_br       (should_br),
    .jump            (jump),
    .ALU_result      (ALU_result),
    .bios_addrb      (bios_addrb),
    .bios_doutb      (bios_doutb),
    .imem_addrb      (imem_addrb),
    .imem_doutb      (imem_doutb),
    .PC              (PC),
    .instruction_EXE (instruction_EXE),
    .valid_EXE       (valid_EXE),
    .cycle_cnt       (cycle_cnt),
    .instret_cnt     (instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memories with one cycle of latency
  always @(posedge clk) begin
    bios_doutb <= bios_mem[bios_addrb];
    imem_doutb <= imem_mem[imem_addrb];
  end

  function automatic bit mapped(input logic [31:0] a);
    return (a[31:28] == 4'h4) || (a[31:28] == 4'h1);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a[31:28] == 4'h4) return bios_mem[a[13:2]];
    else return imem_mem[a[15:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Apply one cycle of inputs, predict outputs, advance the model.
  task automatic step(input bit r, input bit s, input bit b, input bit j, input logic [31:0] t);
    exp_t        e;
    logic [31:0] nxt;
    bit          v;
    v          = 1'b0;
    rst        = r;
    stall      = s;
    should_br  = b;
    jump       = j;
    ALU_result = t;
    if (r)                 nxt = RST_PC;
    else if (m_first || s) nxt = m_pc;
    else if (b || j)       nxt = {t[31:2], 2'b00};
    else                   nxt = m_pc + 32'd4;
    if (m_known) begin
      v       = !m_first && mapped(m_pc);
      e.pc    = m_pc;
      e.instr = v ? word_at(m_pc) : NOP;
      e.valid = v;
      e.cyc   = m_cyc;
      e.inst  = m_inst;
      e.ba    = nxt[13:2];
      e.ia    = nxt[15:2];
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_pc    = RST_PC;
      m_first = 1'b1;
      m_cyc   = 32'd0;
      m_inst  = 32'd0;
      m_known = 1'b1;
    end else begin
      if (v && !s) m_inst = m_inst + 32'd1;
      m_cyc   = m_cyc + 32'd1;
      m_pc    = nxt;
      m_first = 1'b0;
    end
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("PC",          PC,                  e.pc);
        chk("instruction", instruction_EXE,     e.instr);
        chk("valid",       {31'd0, valid_EXE},  {31'd0, e.valid});
        chk("cycle_cnt",   cycle_cnt,           e.cyc);
        chk("instret_cnt", instret_cnt,         e.inst);
        chk("bios_addrb",  {20'd0, bios_addrb}, {20'd0, e.ba});
        chk("imem_addrb",  {18'd0, imem_addrb}, {18'd0, e.ia});
      end
    end
  end

  initial begin
    logic [31:0] r32;
    logic [3:0]  nib;
    for (int i = 0; i < 4096; i++)  bios_mem[i] = $urandom();
    for (int i = 0; i < 16384; i++) imem_mem[i] = $urandom();
    bios_mem[0]  = 32'h0000_0093;
    imem_mem[64] = 32'hCAFE_0001;

    // Reset, release, straight-line fetch from BIOS
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Jump into IMEM with misaligned target
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0102);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Stall with a pending branch, then the branch resolves unstalled
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h4000_0040);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0040);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Redirect to unmapped space
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h2000_0000);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // PC wrap-around at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Reset in the middle of a stall with a redirect pending
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0200);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_0300);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r32 = $urandom();
      case ($urandom_range(0, 5))
        0, 1:    nib = 4'h4;
        2, 3:    nib = 4'h1;
        4:       nib = 4'h2;
        default: nib = 4'hF;
      endcase
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           {nib, r32[27:0]});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, sets the first fetch address after reset (BIOS base).
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hold PC, instruction and fetch address this cycle.
REQ-006 should_br  input  1  conditional branch taken, resolved in EX this cycle.
REQ-007 jump  input  1  JAL/JALR in EX this cycle.
REQ-008 ALU_result  input  32  redirect target computed in EX.
REQ-009 bios_addrb  output  12  BIOS word address, driven from pc_next[13:2].
REQ-010 bios_doutb  input  32  BIOS read data, synchronous read, 1-cycle latency.
REQ-011 imem_addrb  output  14  IMEM word address, driven from pc_next[15:2].
REQ-012 imem_doutb  input  32  IMEM read data, synchronous read, 1-cycle latency.
REQ-013 PC  output  32  address of the instruction on instruction_EXE.
REQ-014 instruction_EXE  output  32  instruction presented to EX.
REQ-015 valid_EXE  output  1  instruction_EXE is a real fetched instruction, not a bubble.
REQ-016 cycle_cnt  output  32  cycles elapsed since reset.
REQ-017 instret_cnt  output  32  instructions retired out of EX.

Function
REQ-018 Internal register pc_q drives PC; pc_next is combinational: stall ? pc_q : (should_br|jump) ? {ALU_result[31:2],2'b00} : pc_q+4.
REQ-019 Both memory address outputs are driven from pc_next every cycle, so read data in cycle t+1 corresponds to pc_q in cycle t+1 (zero-bubble redirect).
REQ-020 Region decode on pc_next[31:28] selects the source: 4'h4 selects BIOS; 4'h1 selects IMEM; any other value is unmapped.
REQ-021 The region decode is registered as src_q alongside pc_q and selects bios_doutb or imem_doutb.
REQ-022 stall has priority over should_br/jump; a redirect asserted during stall is ignored because EX re-resolves it next cycle.
REQ-023 During stall, pc_q, src_q and instruction_EXE are held, and memory is re-addressed with pc_q.
REQ-024 instruction_EXE equals the selected memory data when valid_EXE=1; otherwise it equals NOP_INSTR.
REQ-025 valid_EXE=0 in the first cycle after reset deassertion (memory output not yet valid) and whenever src_q is unmapped.
REQ-026 An unmapped fetch does not stop the PC; the PC keeps incrementing.
REQ-027 Target bits [1:0] are forced to 0; there is no misaligned-fetch exception.
REQ-028 pc_q+4 wraps modulo 2^32.
REQ-029 cycle_cnt increments by 1 every cycle rst=0 and wraps modulo 2^32.
REQ-030 instret_cnt increments when valid_EXE=1 and stall=0, and wraps modulo 2^32.

Reset
REQ-031 While rst=1: pc_q=RESET_PC, src_q=BIOS, valid_EXE=0, instruction_EXE=NOP_INSTR, cycle_cnt=0, instret_cnt=0.
REQ-032 While rst=1, memory addresses are driven from RESET_PC, so the first post-reset cycle reads RESET_PC.
REQ-033 rst asserted mid-operation, including during stall or redirect, overrides all other inputs the same edge.

Structure
REQ-034 RESET_PC default, NOP_INSTR, region codes (4'h4 BIOS, 4'h1 IMEM) and the source-select enum belong in the shared pipeline package.
REQ-035 One sub-module, pc_gen, contains pc_q, pc_next logic and the region decode; counters, output mux and the valid flag stay in if_stage.

Verification
REQ-036 Reset release, BIOS word 0 = 32'h0000_0093: cycle 1 valid_EXE=0, NOP; cycle 2 PC=32'h4000_0000, instruction=32'h0000_0093, valid=1.
REQ-037 Straight-line run of 4 cycles: PC sequence 4000_0000, 4000_0004, 4000_0008, 4000_000C; instret_cnt=4.
REQ-038 jump=1 with ALU_result=32'h1000_0102 -> next cycle PC=32'h1000_0100, src IMEM, instruction=imem[64].
REQ-039 stall=1 for 3 cycles together with should_br=1 -> PC/instruction unchanged 3 cycles, instret_cnt unchanged, cycle_cnt +3, redirect taken in the first unstalled cycle.
REQ-040 Redirect to 32'h2000_0000 -> valid_EXE=0, instruction=NOP, PC advances 2000_0004 next cycle.
REQ-041 Preload cycle_cnt path to 32'hFFFF_FFFF, then 1 cycle -> cycle_cnt=0; rst pulse mid-stall -> PC=4000_0000, counters 0.
